mux_arb_reg: RTL and testbench

MUX_ARB_REG -- requirements
Module: mux_arb_reg

---
 rtl/mux_arb_reg_pkg.sv | 13 +
 rtl/mux_arb_reg_rr_pick.sv | 30 +++
 rtl/mux_arb_reg.sv | 124 ++++++++++++
 tb/tb_mux_arb_reg.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_reg_pkg.sv
// Shared mux library package: default channel count / data width and the
// select-width helper used to size channel-index ports.
package mux_arb_reg_pkg;

   localparam int MUX_DEF_N = 8;
   localparam int MUX_DEF_W = 32;

   // Width of a channel index for n channels; never narrower than one bit.
   function automatic int mux_sel_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux_arb_reg_rr_pick.sv
// Round-robin picker: one-hot grant to the first requester at or above ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick
   import mux_arb_reg_pkg::*;
#(
   parameter int N  = MUX_DEF_N,
   parameter int SW = mux_sel_w(MUX_DEF_N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  grant
);

   // Rotating priority search starting at ptr.
   always_comb begin
      logic          found;
      logic [SW-1:0] idx;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = SW'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel mux/arbiter with a single registered output stage (valid/ready).
// Explicit select by default; defining MUX_ARB_RR_EN adds the round-robin
// mode (mode=1) with its rotating pointer. Without the macro, mode is ignored.
module mux_arb_reg
   import mux_arb_reg_pkg::*;
#(
   parameter int  N  = MUX_DEF_N,
   parameter int  W  = MUX_DEF_W,
   localparam int SW = mux_sel_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mode,
   input  logic [SW-1:0] sel,
   input  logic [N-1:0]  in_valid,
   input  logic [N*W-1:0] in_data,
   output logic [N-1:0]  in_ready,
   output logic          out_valid,
   output logic [W-1:0]  out_data,
   output logic [SW-1:0] out_sel,
   input  logic          out_ready
);

   logic          load_en;
   logic [N-1:0]  grant;
   logic [N-1:0]  grant_exp;
   logic          any_grant;
   logic [SW-1:0] gnt_idx;
   logic [W-1:0]  ch_data [N];

   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_data_q,  out_data_d;
   logic [SW-1:0] out_sel_q,   out_sel_d;

   for (genvar g = 0; g < N; g++) begin : g_ch
      assign ch_data[g] = in_data[g*W +: W];
   end

   // Output stage can take a new word when empty or being drained this cycle.
   assign load_en = !out_valid_q || out_ready;

   // Explicit select; an out-of-range sel matches no channel, so no grant.
   always_comb begin
      grant_exp = '0;
      for (int k = 0; k < N; k++) begin
         if (sel == SW'(k)) grant_exp[k] = in_valid[k];
      end
   end

`ifdef MUX_ARB_RR_EN
   logic [SW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  grant_rr;

   rr_pick #(.N(N), .SW(SW)) u_rr_pick (
      .req   (in_valid),
      .ptr   (ptr_q),
      .grant (grant_rr)
   );

   assign grant = mode ? grant_rr : grant_exp;

   // Pointer moves past the winner only on a round-robin transfer.
   always_comb begin
      ptr_d = ptr_q;
      if (mode && load_en && any_grant) begin
         ptr_d = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign grant       = grant_exp;
`endif

   // Encode the one-hot grant into a channel index.
   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (grant[k]) gnt_idx = SW'(k);
      end
   end

   assign any_grant = |grant;
   // Gating with rst_n keeps every ready low while reset is held.
   assign in_ready  = (rst_n && load_en) ? grant : '0;

   // Next output stage: load on grant, go empty on no grant, else hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (load_en) begin
         out_valid_d = any_grant;
         if (any_grant) begin
            out_data_d = ch_data[gnt_idx];
            out_sel_d  = gnt_idx;
         end
      end
   end

   // Output stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of the output stage.
// Round-robin scenarios are included when MUX_ARB_RR_EN is defined.
module tb_mux_arb_reg;

   localparam int N  = 8;
   localparam int W  = 32;
   localparam int SW = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_sel;
   logic           out_ready;

   int total = 0;
   int bad   = 0;

   // model state: what the output register must hold right now
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_sel;
   int           m_ptr;

   mux_arb_reg #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model compare and advance on the falling edge, when inputs are stable.
   always @(negedge clk) begin
      int           idx;
      int           j;
      bit           found;
      bit           rr;
      bit           load;
      logic [N-1:0] exp_rdy;
      if (!rst_n) begin
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_out_data", 64'(out_data), 64'd0);
         chk("rst_out_sel", 64'(out_sel), 64'd0);
         chk("rst_in_ready", 64'(in_ready), 64'd0);
         m_valid = 1'b0;
         m_data  = '0;
         m_sel   = 0;
         m_ptr   = 0;
      end else begin
         chk("model_out_valid", 64'(out_valid), 64'(m_valid));
         if (m_valid) begin
            chk("model_out_data", 64'(out_data), 64'(m_data));
            chk("model_out_sel", 64'(out_sel), 64'(m_sel));
         end
         rr = 1'b0;
`ifdef MUX_ARB_RR_EN
         rr = mode;
`endif
         found = 1'b0;
         idx   = 0;
         if (rr) begin
            for (int i = 0; i < N; i++) begin
               j = (m_ptr + i) % N;
               if (!found && in_valid[j]) begin
                  found = 1'b1;
                  idx   = j;
               end
            end
         end else if (int'(sel) < N && in_valid[sel]) begin
            found = 1'b1;
            idx   = int'(sel);
         end
         load    = !m_valid || out_ready;
         exp_rdy = '0;
         if (load && found) exp_rdy[idx] = 1'b1;
         chk("model_in_ready", 64'(in_ready), 64'(exp_rdy));
         if (load) begin
            m_valid = found;
            if (found) begin
               m_data = in_data[idx*W +: W];
               m_sel  = idx;
               if (rr) m_ptr = (idx + 1) % N;
            end
         end
      end
   end

   task automatic set_in(input logic m, input int s, input logic [N-1:0] v, input logic rdy);
      mode      = m;
      sel       = SW'(s);
      in_valid  = v;
      out_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] ch_pat(input int k);
      return (k == 3) ? 32'hDEADBEEF : (32'hA0000000 | (32'h01010101 * 32'(k)));
   endfunction

   initial begin
      rst_n = 1'b0;
      set_in(1'b0, 0, '0, 1'b0);
      for (int k = 0; k < N; k++) in_data[k*W +: W] = ch_pat(k);
      tick();
      tick();
      rst_n = 1'b1;
      chk("post_reset_valid", 64'(out_valid), 64'd0);

      // first cycle after release: explicit transfer from channel 3
      set_in(1'b0, 3, 8'h08, 1'b1);
      #1 chk("exp_in_ready", 64'(in_ready), 64'h08);
      tick();
      chk("exp_out_valid", 64'(out_valid), 64'd1);
      chk("exp_out_data", 64'(out_data), 64'hDEADBEEF);
      chk("exp_out_sel", 64'(out_sel), 64'd3);

      // backpressure for four cycles with everybody requesting
      set_in(1'b0, 3, 8'hFF, 1'b0);
      for (int c = 0; c < 4; c++) begin
         #1 chk("bp_in_ready", 64'(in_ready), 64'h00);
         tick();
         chk("bp_out_data", 64'(out_data), 64'hDEADBEEF);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      set_in(1'b0, 6, 8'hFF, 1'b1);
      #1 chk("resume_in_ready", 64'(in_ready), 64'h40);
      tick();
      chk("resume_out_sel", 64'(out_sel), 64'd6);
      chk("resume_out_data", 64'(out_data), 64'(ch_pat(6)));

      // explicit back-to-back with sel changing every cycle
      set_in(1'b0, 1, 8'hFF, 1'b1);
      tick();
      chk("b2b_sel1", 64'(out_sel), 64'd1);
      set_in(1'b0, 7, 8'hFF, 1'b1);
      tick();
      chk("b2b_sel7", 64'(out_sel), 64'd7);
      chk("b2b_data7", 64'(out_data), 64'(ch_pat(7)));
      set_in(1'b0, 6, 8'hFF, 1'b1);
      tick();

      // selected channel idle: drain, go empty, hold data and sel
      set_in(1'b0, 5, 8'hDF, 1'b1);
      #1 chk("nogrant_in_ready", 64'(in_ready), 64'h00);
      tick();
      chk("nogrant_out_valid", 64'(out_valid), 64'd0);
      chk("nogrant_hold_data", 64'(out_data), 64'(ch_pat(6)));
      chk("nogrant_hold_sel", 64'(out_sel), 64'd6);

      // empty stage accepts even with out_ready low, then holds
      set_in(1'b0, 2, 8'h04, 1'b0);
      #1 chk("empty_in_ready", 64'(in_ready), 64'h04);
      tick();
      chk("empty_load_sel", 64'(out_sel), 64'd2);
      tick();
      chk("empty_hold_valid", 64'(out_valid), 64'd1);
      chk("empty_hold_data", 64'(out_data), 64'(ch_pat(2)));
      set_in(1'b0, 0, 8'h00, 1'b1);
      tick();

`ifdef MUX_ARB_RR_EN
      // full round-robin sweep from ptr=0 (explicit transfers left it alone)
      set_in(1'b1, 0, 8'hFF, 1'b1);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("rr_seq_sel", 64'(out_sel), 64'(i % N));
         chk("rr_seq_valid", 64'(out_valid), 64'd1);
      end
      // ptr now 1; channel 5 alone moves it to 6
      set_in(1'b1, 0, 8'h20, 1'b1);
      tick();
      chk("rr_ch5", 64'(out_sel), 64'd5);
      set_in(1'b1, 0, 8'h05, 1'b1);
      tick();
      chk("rr_wrap_ch0", 64'(out_sel), 64'd0);
      tick();
      chk("rr_wrap_ch2", 64'(out_sel), 64'd2);
      // explicit transfer must not move ptr (stays 3)
      set_in(1'b0, 7, 8'h80, 1'b1);
      tick();
      chk("rr_explicit7", 64'(out_sel), 64'd7);
      set_in(1'b1, 0, 8'hFF, 1'b1);
      tick();
      chk("rr_after_exp", 64'(out_sel), 64'd3);
`else
      // mode is ignored: still explicit select
      set_in(1'b1, 4, 8'hFF, 1'b1);
      tick();
      chk("mode_ignored_sel", 64'(out_sel), 64'd4);
      chk("mode_ignored_data", 64'(out_data), 64'(ch_pat(4)));
`endif

      // asynchronous reset while holding a word
      set_in(1'b0, 3, 8'h08, 1'b0);
      tick();
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_data", 64'(out_data), 64'd0);
      chk("async_rst_sel", 64'(out_sel), 64'd0);
      chk("async_rst_ready", 64'(in_ready), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
`ifdef MUX_ARB_RR_EN
      set_in(1'b1, 0, 8'hFF, 1'b1);
      tick();
      chk("rr_ptr_reset", 64'(out_sel), 64'd0);
      tick();
      chk("rr_ptr_reset_next", 64'(out_sel), 64'd1);
`else
      set_in(1'b0, 5, 8'hFF, 1'b1);
      tick();
      chk("post_rst_sel", 64'(out_sel), 64'd5);
`endif

      // randomised traffic checked by the model, with one reset pulse
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom;
         set_in(1'($urandom_range(0, 1)), $urandom_range(0, N-1),
                N'($urandom), ($urandom_range(0, 3) != 0));
         rst_n = (c == 150) ? 1'b0 : 1'b1;
         tick();
      end
      rst_n = 1'b1;
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
